// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/stall controller: derives PC and pipeline-latch load enables,
// bubble injection, branch redirect and fetch squash, plus stall/flush counters.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_read,
    input  logic        imem_resp,
    input  logic        dmem_req,
    input  logic        dmem_resp,
    input  logic        idex_is_load,
    input  logic [2:0]  idex_dest,
    input  logic [2:0]  ifid_sr1,
    input  logic [2:0]  ifid_sr2,
    input  logic        ifid_use_sr1,
    input  logic        ifid_use_sr2,
    input  logic        br_taken,
    output logic        load_pc,
    output logic        load_ifid,
    output logic        load_idex,
    output logic        load_exmem,
    output logic        load_memwb,
    output logic        bubble_ifid,
    output logic        bubble_idex,
    output logic        bubble_exmem,
    output logic        pc_redirect,
    output logic        imem_squash,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        state_dbg
);

    typedef enum logic {RUN = 1'b0, SQUASH = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        dstall, istall, hazard;

    // Memory handshakes: a request (imem_read / dmem_req) stays high until the
    // cycle its response (imem_resp / dmem_resp) is high; that cycle completes it.
    assign dstall = dmem_req & ~dmem_resp;
    assign istall = imem_read & ~imem_resp;
    assign hazard = idex_is_load &
                    ((ifid_use_sr1 & (ifid_sr1 == idex_dest)) |
                     (ifid_use_sr2 & (ifid_sr2 == idex_dest)));

    always_comb begin
        load_pc      = 1'b1;
        load_ifid    = 1'b1;
        load_idex    = 1'b1;
        load_exmem   = 1'b1;
        load_memwb   = 1'b1;
        bubble_ifid  = 1'b0;
        bubble_idex  = 1'b0;
        bubble_exmem = 1'b0;
        pc_redirect  = 1'b0;
        imem_squash  = 1'b0;
        state_d      = state_q;
        flush_cnt_d  = flush_cnt_q;

        if (reset) begin
            bubble_ifid  = 1'b1;
            bubble_idex  = 1'b1;
            bubble_exmem = 1'b1;
            state_d      = RUN;
        end else if (dstall) begin
            // Whole pipe freezes; a pending squash keeps discarding fetch data.
            load_pc     = 1'b0;
            load_ifid   = 1'b0;
            load_idex   = 1'b0;
            load_exmem  = 1'b0;
            load_memwb  = 1'b0;
            imem_squash = (state_q == SQUASH);
        end else if (br_taken) begin
            bubble_ifid  = 1'b1;
            bubble_idex  = 1'b1;
            bubble_exmem = 1'b1;
            pc_redirect  = 1'b1;
            flush_cnt_d  = flush_cnt_q + 16'd1;
            state_d      = istall ? SQUASH : RUN;
        end else if (state_q == SQUASH) begin
            // Wrong-path fetch still in flight: drop its response when it lands.
            imem_squash = 1'b1;
            load_pc     = 1'b0;
            bubble_ifid = 1'b1;
            state_d     = imem_resp ? RUN : SQUASH;
        end else if (istall) begin
            load_pc     = 1'b0;
            bubble_ifid = 1'b1;
        end else if (hazard) begin
            load_pc     = 1'b0;
            load_ifid   = 1'b0;
            bubble_idex = 1'b1;
        end

        stall_cnt_d = stall_cnt_q + {15'd0, ~load_pc};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign state_dbg = (state_q == SQUASH);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hand-computed control vectors and counters
// checked with immediate assertions.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        imem_read, imem_resp, dmem_req, dmem_resp;
    logic        idex_is_load;
    logic [2:0]  idex_dest, ifid_sr1, ifid_sr2;
    logic        ifid_use_sr1, ifid_use_sr2;
    logic        br_taken;
    logic        load_pc, load_ifid, load_idex, load_exmem, load_memwb;
    logic        bubble_ifid, bubble_idex, bubble_exmem;
    logic        pc_redirect, imem_squash;
    logic [15:0] stall_cnt, flush_cnt;
    logic        state_dbg;

    int vectors    = 0;
    int miscompares = 0;

    // {load_pc,load_ifid,load_idex,load_exmem,load_memwb,
    //  bubble_ifid,bubble_idex,bubble_exmem,pc_redirect,imem_squash}
    localparam logic [9:0] C_RESET  = 10'b11111_111_00;
    localparam logic [9:0] C_NORMAL = 10'b11111_000_00;
    localparam logic [9:0] C_HAZARD = 10'b00111_010_00;
    localparam logic [9:0] C_DSTALL = 10'b00000_000_00;
    localparam logic [9:0] C_BRANCH = 10'b11111_111_10;
    localparam logic [9:0] C_SQUASH = 10'b01111_100_01;
    localparam logic [9:0] C_ISTALL = 10'b01111_100_00;

    pipeline_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_read(imem_read), .imem_resp(imem_resp),
        .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .idex_is_load(idex_is_load), .idex_dest(idex_dest),
        .ifid_sr1(ifid_sr1), .ifid_sr2(ifid_sr2),
        .ifid_use_sr1(ifid_use_sr1), .ifid_use_sr2(ifid_use_sr2),
        .br_taken(br_taken),
        .load_pc(load_pc), .load_ifid(load_ifid), .load_idex(load_idex),
        .load_exmem(load_exmem), .load_memwb(load_memwb),
        .bubble_ifid(bubble_ifid), .bubble_idex(bubble_idex),
        .bubble_exmem(bubble_exmem),
        .pc_redirect(pc_redirect), .imem_squash(imem_squash),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] ctrl();
        return {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
                bubble_ifid, bubble_idex, bubble_exmem, pc_redirect, imem_squash};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1-3 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic idle_inputs();
        imem_read = 1'b1; imem_resp = 1'b1;
        dmem_req = 1'b0;  dmem_resp = 1'b0;
        idex_is_load = 1'b0; idex_dest = 3'd0;
        ifid_sr1 = 3'd0; ifid_sr2 = 3'd0;
        ifid_use_sr1 = 1'b0; ifid_use_sr2 = 1'b0;
        br_taken = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        imem_read = 1'b0; imem_resp = 1'b0;

        // Two reset cycles
        step();
        settle();
        chk("reset_ctrl", {6'd0, ctrl()}, {6'd0, C_RESET});
        chk("reset_stall", stall_cnt, 16'h0000);
        chk("reset_flush", flush_cnt, 16'h0000);
        chk("reset_state", {15'd0, state_dbg}, 16'd0);
        step();

        // Idle fetch running
        reset = 1'b0;
        idle_inputs();
        settle();
        chk("idle_ctrl", {6'd0, ctrl()}, {6'd0, C_NORMAL});
        step();
        chk("idle_stall", stall_cnt, 16'h0000);

        // Load-use hazard on sr2
        idex_is_load = 1'b1; idex_dest = 3'd3;
        ifid_sr1 = 3'd5; ifid_use_sr1 = 1'b1;
        ifid_sr2 = 3'd3; ifid_use_sr2 = 1'b1;
        settle();
        chk("hazard_ctrl", {6'd0, ctrl()}, {6'd0, C_HAZARD});
        step();
        idex_is_load = 1'b0;
        settle();
        chk("post_hazard_ctrl", {6'd0, ctrl()}, {6'd0, C_NORMAL});
        chk("hazard_stall", stall_cnt, 16'd1);
        step();

        // Matching source but not read: no hazard
        idex_is_load = 1'b1; idex_dest = 3'd6;
        ifid_sr1 = 3'd6; ifid_use_sr1 = 1'b0;
        ifid_sr2 = 3'd1; ifid_use_sr2 = 1'b1;
        settle();
        chk("unused_src_ctrl", {6'd0, ctrl()}, {6'd0, C_NORMAL});
        step();

        // R0 is an ordinary register
        idex_dest = 3'd0; ifid_sr1 = 3'd0; ifid_use_sr1 = 1'b1; ifid_use_sr2 = 1'b0;
        settle();
        chk("r0_hazard_ctrl", {6'd0, ctrl()}, {6'd0, C_HAZARD});
        step();
        idle_inputs();
        chk("r0_stall", stall_cnt, 16'd2);

        // Data stall for 4 cycles with a taken branch held off
        dmem_req = 1'b1; dmem_resp = 1'b0; br_taken = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("dstall_ctrl", {6'd0, ctrl()}, {6'd0, C_DSTALL});
            step();
        end
        chk("dstall_stall", stall_cnt, 16'd6);
        chk("dstall_flush", flush_cnt, 16'd0);
        dmem_resp = 1'b1;
        settle();
        chk("dstall_release_redirect", {6'd0, ctrl()}, {6'd0, C_BRANCH});
        step();
        chk("dstall_flush_after", flush_cnt, 16'd1);
        chk("dstall_state_after", {15'd0, state_dbg}, 16'd0);
        idle_inputs();

        // Taken branch while fetch is outstanding -> SQUASH
        imem_resp = 1'b0; br_taken = 1'b1;
        settle();
        chk("br_istall_ctrl", {6'd0, ctrl()}, {6'd0, C_BRANCH});
        step();
        br_taken = 1'b0;
        chk("squash_entry_state", {15'd0, state_dbg}, 16'd1);
        chk("squash_flush", flush_cnt, 16'd2);
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("squash_wait_ctrl", {6'd0, ctrl()}, {6'd0, C_SQUASH});
            step();
            chk("squash_wait_state", {15'd0, state_dbg}, 16'd1);
        end
        imem_resp = 1'b1;
        settle();
        chk("squash_resp_ctrl", {6'd0, ctrl()}, {6'd0, C_SQUASH});
        step();
        chk("squash_exit_state", {15'd0, state_dbg}, 16'd0);
        chk("squash_stall", stall_cnt, 16'd9);
        settle();
        chk("post_squash_ctrl", {6'd0, ctrl()}, {6'd0, C_NORMAL});

        // Plain fetch stall in RUN
        imem_resp = 1'b0;
        settle();
        chk("istall_ctrl", {6'd0, ctrl()}, {6'd0, C_ISTALL});
        step();
        chk("istall_state", {15'd0, state_dbg}, 16'd0);
        chk("istall_stall", stall_cnt, 16'd10);

        // Branch into SQUASH, then a second branch while in SQUASH
        br_taken = 1'b1;
        step();
        chk("squash2_state", {15'd0, state_dbg}, 16'd1);
        settle();
        chk("br_in_squash_ctrl", {6'd0, ctrl()}, {6'd0, C_BRANCH});
        step();
        br_taken = 1'b0;
        chk("br_in_squash_state", {15'd0, state_dbg}, 16'd1);
        chk("br_in_squash_flush", flush_cnt, 16'd4);

        // Data stall while in SQUASH holds the state
        dmem_req = 1'b1; dmem_resp = 1'b0; imem_resp = 1'b1;
        settle();
        chk("dstall_squash_ctrl", {7'd0, ctrl() >> 1}, {7'd0, C_DSTALL >> 1});
        step();
        chk("dstall_squash_state", {15'd0, state_dbg}, 16'd1);
        chk("dstall_squash_stall", stall_cnt, 16'd11);

        // Reset from SQUASH with a data stall pending
        reset = 1'b1;
        settle();
        chk("reset_in_squash_ctrl", {6'd0, ctrl()}, {6'd0, C_RESET});
        step();
        chk("reset_in_squash_state", {15'd0, state_dbg}, 16'd0);
        chk("reset_in_squash_stall", stall_cnt, 16'h0000);
        chk("reset_in_squash_flush", flush_cnt, 16'h0000);
        reset = 1'b0;
        idle_inputs();
        imem_resp = 1'b0;
        settle();
        chk("post_reset_istall_ctrl", {6'd0, ctrl()}, {6'd0, C_ISTALL});
        chk("post_reset_squash", {15'd0, imem_squash}, 16'd0);
        step();
        chk("post_reset_stall", stall_cnt, 16'd1);

        // stall_cnt wrap
        reset = 1'b1;
        idle_inputs();
        step();
        reset = 1'b0;
        dmem_req = 1'b1; dmem_resp = 1'b0;
        for (int i = 0; i < 65535; i++) step();
        chk("stall_full", stall_cnt, 16'hFFFF);
        step();
        chk("stall_wrap", stall_cnt, 16'h0000);
        chk("wrap_flush", flush_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
